rgb_pwm: RTL and testbench
==========================

RGB_PWM -- requirements
Module: rgb_pwm

Interface
REQ-001 Parameter PRESCALE, default 1, SHALL set the number of clk cycles per PWM step (legal range 1..65535).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 enable  input  1  SHALL run the PWM when high, and hold the PWM with LEDs dark when low.
REQ-005 rgb  input  24  SHALL carry the colour code: [23:16] red duty, [15:8] green duty, [7:0] blue duty.
REQ-006 rgb_valid  input  1  SHALL qualify rgb for capture, one cycle per new value.
REQ-007 led_r, led_g, led_b  output  1 each  SHALL be the registered PWM drive per channel.
REQ-008 period_start  output  1  SHALL be a registered one-cycle pulse marking step 0 of each PWM period.
REQ-009 pending  output  1  SHALL be high while a captured colour awaits application.

Function
REQ-010 Prescaler: with enable high, presc SHALL count 0..PRESCALE-1 and wrap; tick SHALL be asserted in the cycle presc==PRESCALE-1.
REQ-011 Step counter: step (8 bits) SHALL advance on tick through 0..254, then wrap from 254 to 0; period SHALL be 255*PRESCALE clk cycles.
REQ-012 Wrap event: the wrap event SHALL be tick with step==254.
REQ-013 Capture: rgb_valid high SHALL load rgb into a shadow register and set pending, independent of enable.
REQ-014 Repeated captures: multiple rgb_valid pulses in one period SHALL be last-wins; no queueing.
REQ-015 Apply at wrap: on wrap with pending set, the shadow value SHALL move to the active duty registers and pending SHALL clear.
REQ-016 Capture coincident with wrap: rgb_valid in the same cycle as wrap SHALL load rgb directly into the active duty registers, and pending SHALL be low afterwards.
REQ-017 Duty stability: active duty registers SHALL never change mid-period (glitch-free update).
REQ-018 LED outputs: registered each cycle as led_x = enable AND (step < duty_x); output latency is 1 clk from step/duty.
REQ-019 Duty extremes: duty 0 SHALL give an LED never on; duty 255 SHALL give an LED always on (step max 254).
REQ-020 period_start SHALL be registered high for exactly one cycle following each wrap event, and SHALL never pulse while enable is low.
REQ-021 enable low: presc and step SHALL hold their values; led_x and period_start SHALL be 0 from the next edge.
REQ-022 enable reasserted: counting SHALL resume from the held presc/step values, with no restart.
REQ-023 Shadow path while disabled: capture and pending SHALL continue to operate while enable is low, with application deferred to the next wrap.

Reset
REQ-024 rst_n low SHALL asynchronously clear presc, step, shadow, the active duties, pending, led_r/g/b and period_start to 0.
REQ-025 Reset mid-period SHALL discard any pending colour.
REQ-026 Reset release: after rst_n rises, the first tick SHALL occur PRESCALE cycles after the first enabled edge.

Verification
REQ-027 Bench parameter: the bench SHALL use PRESCALE=1 (period 255 clk) unless a scenario states otherwise.
REQ-028 Scenario 1: reset, enable=1, rgb_valid pulse with rgb=24'hFF8000 -> pending=1 until the first wrap; the next period shows led_r high 255/255 cycles, led_g high 128/255, led_b 0/255.
REQ-029 Scenario 2: mid-period, pulse rgb=24'h000000 then rgb=24'h0000FF -> only 24'h0000FF is applied at the wrap; led_b high every cycle of the next period; current-period duty unchanged.
REQ-030 Scenario 3: rgb_valid coincident with the wrap cycle, rgb=24'h010101 -> applied to the period starting next; each LED high exactly 1 cycle; pending stays 0.
REQ-031 Scenario 4: enable low for 40 cycles mid-period -> LEDs and period_start 0; step frozen; after re-enable the period completes with total length 255 enabled cycles.
REQ-032 Scenario 5: rst_n pulsed low asynchronously (not edge-aligned) while pending=1 and LEDs on -> all outputs 0 immediately; pending 0; post-reset duty 0.
REQ-033 Scenario 6: PRESCALE=4 -> period_start pulses every 1020 cycles; rgb=24'h800000 gives led_r high 512 cycles per period.

Source files
------------

// File: rtl/rgb_pwm.sv
// rgb_pwm: three-channel 8-bit PWM LED driver with a double-buffered colour.
// A new colour is captured into a shadow register and only moved into the
// active duty registers at the end of a PWM period, so a period never mixes
// two colours.
//
// Ports:
//   clk          - single clock, rising edge
//   rst_n        - asynchronous active-low reset
//   enable       - run the PWM; when low the counters hold and the LEDs go dark
//   rgb          - colour code {red, green, blue} duty, 8 bits each
//   rgb_valid    - one-cycle strobe qualifying rgb for capture
//   led_r/g/b    - registered PWM drive per channel
//   period_start - registered one-cycle pulse marking step 0 of each period
//   pending      - a captured colour is waiting for the next period
module rgb_pwm #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [23:0] rgb,
  input  logic        rgb_valid,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b,
  output logic        period_start,
  output logic        pending
);

  localparam int unsigned PW = 16;
  localparam int unsigned SW = 8;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(254);

  typedef struct packed {
    logic [SW-1:0] r;
    logic [SW-1:0] g;
    logic [SW-1:0] b;
  } colour_t;

  logic [PW-1:0] presc;
  logic [SW-1:0] step;
  colour_t       shadow;
  colour_t       duty;
  logic          tick_c;
  logic          wrap_c;

  // One PWM step every PRESCALE enabled cycles; the period ends after step 254.
  assign tick_c = enable && (presc == PRESC_LAST);
  assign wrap_c = tick_c && (step == STEP_LAST);

  // Prescaler and step counter; both freeze while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      step  <= '0;
    end else if (enable) begin
      presc <= tick_c ? '0 : presc + PW'(1);
      if (tick_c) begin
        step <= wrap_c ? '0 : step + SW'(1);
      end
    end
  end

  // Colour double buffer. A capture landing exactly on the wrap goes straight
  // to the active duties, since that is the boundary it would wait for anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      duty    <= '0;
      pending <= 1'b0;
    end else if (rgb_valid) begin
      if (wrap_c) begin
        duty    <= colour_t'(rgb);
        pending <= 1'b0;
      end else begin
        shadow  <= colour_t'(rgb);
        pending <= 1'b1;
      end
    end else if (wrap_c && pending) begin
      duty    <= shadow;
      pending <= 1'b0;
    end
  end

  // Registered LED compare; step never exceeds 254, so duty 255 is always on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r        <= 1'b0;
      led_g        <= 1'b0;
      led_b        <= 1'b0;
      period_start <= 1'b0;
    end else begin
      led_r        <= enable && (step < duty.r);
      led_g        <= enable && (step < duty.g);
      led_b        <= enable && (step < duty.b);
      period_start <= wrap_c;
    end
  end

endmodule

// File: tb/tb_rgb_pwm.sv
module tb_rgb_pwm;

  localparam int unsigned P1      = 1;
  localparam int unsigned PERIOD1 = 255 * P1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, rgb_valid;
  logic [23:0] rgb;
  logic        led_r, led_g, led_b, period_start, pending;

  logic        en4, rgbv4;
  logic [23:0] rgb4;
  logic        led_r4, led_g4, led_b4, ps4, pend4;

  int vectors = 0;
  int miscompares = 0;

  rgb_pwm #(.PRESCALE(P1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rgb(rgb), .rgb_valid(rgb_valid),
    .led_r(led_r), .led_g(led_g), .led_b(led_b),
    .period_start(period_start), .pending(pending)
  );

  rgb_pwm #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(en4), .rgb(rgb4), .rgb_valid(rgbv4),
    .led_r(led_r4), .led_g(led_g4), .led_b(led_b4),
    .period_start(ps4), .pending(pend4)
  );

  always #5 clk = ~clk;

  // Reference model: position within the period is a count of enabled cycles;
  // the step is that count divided by the prescale.
  int unsigned m_cnt;
  logic [23:0] m_duty, m_shadow;
  logic        m_pend, m_r, m_g, m_b, m_ps;

  always @(posedge clk or negedge rst_n) begin : ref_model
    int unsigned st;
    logic        wr;
    if (!rst_n) begin
      m_cnt = 0; m_duty = '0; m_shadow = '0; m_pend = 1'b0;
      m_r = 1'b0; m_g = 1'b0; m_b = 1'b0; m_ps = 1'b0;
    end else begin
      st   = m_cnt / P1;
      wr   = enable && (m_cnt == PERIOD1 - 1);
      m_r  = enable && (st < 32'(m_duty[23:16]));
      m_g  = enable && (st < 32'(m_duty[15:8]));
      m_b  = enable && (st < 32'(m_duty[7:0]));
      m_ps = wr;
      if (rgb_valid) begin
        if (wr) begin m_duty = rgb; m_pend = 1'b0; end
        else    begin m_shadow = rgb; m_pend = 1'b1; end
      end else if (wr && m_pend) begin
        m_duty = m_shadow; m_pend = 1'b0;
      end
      if (enable) m_cnt = (m_cnt + 1) % PERIOD1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Count negedges until period_start is seen (0 if never within the bound).
  task automatic wait_ps(output int n);
    n = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (period_start) begin n = k; break; end
    end
  endtask

  typedef struct {
    int          p1_at;
    logic [23:0] p1;
    int          p2_at;
    logic [23:0] p2;
    int          er, eg, eb;
    int          epmid;
  } vec_t;

  vec_t tbl[7];

  // One full period, starting at the sample where period_start was seen.
  // Iteration i drives the inputs for the edge that produces sample i.
  task automatic run_window(input vec_t v, input int idx);
    int cr = 0, cg = 0, cb = 0, cps = 0, pmid = 0, pend_end = 0, ps_last = 0;
    for (int i = 0; i < 255; i++) begin
      rgb_valid = 1'b0;
      if (i == v.p1_at) begin rgb = v.p1; rgb_valid = 1'b1; end
      if (i == v.p2_at) begin rgb = v.p2; rgb_valid = 1'b1; end
      @(negedge clk);
      cr  += int'(led_r);
      cg  += int'(led_g);
      cb  += int'(led_b);
      cps += int'(period_start);
      if (i == 100) pmid = int'(pending);
      if (i == 254) begin pend_end = int'(pending); ps_last = int'(period_start); end
    end
    rgb_valid = 1'b0;
    chk($sformatf("row%0d_red_on", idx),   cr, v.er);
    chk($sformatf("row%0d_green_on", idx), cg, v.eg);
    chk($sformatf("row%0d_blue_on", idx),  cb, v.eb);
    chk($sformatf("row%0d_ps_count", idx), cps, 1);
    chk($sformatf("row%0d_ps_last", idx),  ps_last, 1);
    chk($sformatf("row%0d_pend_mid", idx), pmid, v.epmid);
    chk($sformatf("row%0d_pend_end", idx), pend_end, 0);
  endtask

  initial begin
    int n, r_cnt, dis_bad, jb, c4r, c4gb, c4ps, ps4_last;
    vec_t zero_row;

    tbl[0] = '{10,  24'hFF8000, -1, 24'h000000,   0,   0,   0, 1};
    tbl[1] = '{50,  24'h000000, 51, 24'h0000FF, 255, 128,   0, 1};
    tbl[2] = '{254, 24'h010101, -1, 24'h000000,   0,   0, 255, 0};
    tbl[3] = '{120, 24'h7F0140, -1, 24'h000000,   1,   1,   1, 0};
    tbl[4] = '{-1,  24'h000000, -1, 24'h000000, 127,   1,  64, 0};
    tbl[5] = '{0,   24'h000000, -1, 24'h000000, 127,   1,  64, 1};
    tbl[6] = '{5,   24'hFFFFFF, -1, 24'h000000,   0,   0,   0, 1};
    zero_row = '{-1, 24'h000000, -1, 24'h000000, 0, 0, 0, 0};

    rst_n = 1'b0; enable = 1'b0; rgb = '0; rgb_valid = 1'b0;
    en4 = 1'b0; rgb4 = '0; rgbv4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", int'({led_r, led_g, led_b, period_start, pending}), 0);
    chk("reset_outs4", int'({led_r4, led_g4, led_b4, ps4, pend4}), 0);

    rst_n = 1'b1; enable = 1'b1;
    wait_ps(n);
    chk("first_wrap_after_reset", n, 255);

    for (int k = 0; k < 7; k++) run_window(tbl[k], k);

    // Enable low for 40 cycles mid-period with duty FFFFFF.
    r_cnt = 0; dis_bad = 0; jb = -1;
    for (int j = 0; j < 400; j++) begin
      enable = (j < 100 || j >= 140);
      @(negedge clk);
      r_cnt += int'(led_r);
      if (j >= 100 && j < 140 && (led_r || led_g || led_b || period_start)) dis_bad++;
      if (period_start) begin jb = j; break; end
    end
    enable = 1'b1;
    chk("dis_outputs_dark", dis_bad, 0);
    chk("dis_period_len", jb, 294);
    chk("dis_red_on", r_cnt, 255);

    // Asynchronous reset while a colour is pending and LEDs are lit.
    rgb = 24'h00FF00; rgb_valid = 1'b1;
    @(negedge clk);
    rgb_valid = 1'b0;
    chk("s5_pending_set", int'(pending), 1);
    chk("s5_led_on", int'({led_r, led_g, led_b}), 7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("s5_async_outs", int'({led_r, led_g, led_b, period_start, pending}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ps(n);
    chk("s5_first_wrap", n, 255);
    run_window(zero_row, 7);

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      enable    = ($urandom_range(0, 99) < 88);
      rgb_valid = ($urandom_range(0, 99) < 4);
      rgb       = 24'($urandom());
      @(negedge clk);
      chk("rand_outs", int'({led_r, led_g, led_b, period_start, pending}),
          int'({m_r, m_g, m_b, m_ps, m_pend}));
    end
    enable = 1'b0; rgb_valid = 1'b0;

    // PRESCALE=4: capture while disabled, then check period and duty.
    rgb4 = 24'h800000; rgbv4 = 1'b1;
    @(negedge clk);
    rgbv4 = 1'b0;
    chk("p4_pending_while_disabled", int'(pend4), 1);
    chk("p4_dark_while_disabled", int'({led_r4, ps4}), 0);
    en4 = 1'b1;
    n = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      if (ps4) begin n = k; break; end
    end
    chk("p4_first_wrap", n, 1020);
    chk("p4_pending_applied", int'(pend4), 0);
    c4r = 0; c4gb = 0; c4ps = 0; ps4_last = 0;
    for (int i = 0; i < 1020; i++) begin
      @(negedge clk);
      c4r  += int'(led_r4);
      c4gb += int'(led_g4 | led_b4);
      c4ps += int'(ps4);
      if (i == 1019) ps4_last = int'(ps4);
    end
    chk("p4_red_on", c4r, 512);
    chk("p4_green_blue_off", c4gb, 0);
    chk("p4_ps_count", c4ps, 1);
    chk("p4_ps_interval", ps4_last, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
